// File: rtl/led_scan_pkg.sv
// Shared constants, frame type and bit-mapping helper for the 8x4 LED matrix scanner.
package led_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 8;

  typedef logic [31:0] frame_t;

  // Frame bit c*8+r lights row r+1 of column c+1.
  function automatic logic [4:0] bit_index(input logic [1:0] col, input logic [2:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot counter and column index for the matrix scan.
// Exposes next-state values so the top level can register outputs in step with the counter.
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int COL_DIV      = 3000,
  parameter int BLANK_CYCLES = 60,
  parameter int CNT_W        = $clog2(COL_DIV)
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [CNT_W-1:0] cnt_next,
  output logic [1:0]       col_next,
  output logic             boundary,
  output logic             on_next,
  output logic             frame_start
);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       col;
  logic             wrap;

  always_comb begin
    wrap     = (cnt == CNT_W'(COL_DIV - 1));
    cnt_next = wrap ? '0 : cnt + CNT_W'(1);
    col_next = wrap ? col + 2'd1 : col;
    boundary = wrap && (col == 2'(NUM_COLS - 1));
    on_next  = (cnt_next >= CNT_W'(BLANK_CYCLES));
  end

  // The frame boundary edge is exactly the edge that lands on column 1, slot 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      col         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      col         <= col_next;
      frame_start <= boundary;
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered, column-multiplexed driver for the iceFUN 8x4 LED matrix.
// Optional global PWM dimming is enabled by defining LED_SCAN_PWM_EN.
module led_matrix_scan
  import led_scan_pkg::*;
#(
  parameter int COL_DIV      = 3000,
  parameter int BLANK_CYCLES = 60
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [2:0]  brightness,
  output logic        frame_start,
  output logic        led1,
  output logic        led2,
  output logic        led3,
  output logic        led4,
  output logic        led5,
  output logic        led6,
  output logic        led7,
  output logic        led8,
  output logic        lcol1,
  output logic        lcol2,
  output logic        lcol3,
  output logic        lcol4
);

  localparam int CNT_W = $clog2(COL_DIV);

  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       col_next;
  logic             boundary;
  logic             on_next;
  logic             lit;

  frame_t disp, disp_next;
  frame_t pend, pend_next;
  logic   pend_full, pend_full_next;
  logic   accept;

  logic [NUM_ROWS-1:0] led_q, led_next;
  logic [NUM_COLS-1:0] lcol_q, lcol_next;

  led_scan_timer #(
    .COL_DIV      (COL_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clock       (clock),
    .reset_n     (reset_n),
    .cnt_next    (cnt_next),
    .col_next    (col_next),
    .boundary    (boundary),
    .on_next     (on_next),
    .frame_start (frame_start)
  );

`ifdef LED_SCAN_PWM_EN
  localparam int ON_LEN = COL_DIV - BLANK_CYCLES;

  logic [CNT_W:0] thr, thr_next, offset;

  // Threshold is latched at the start of each slot so a brightness change never shortens a slot mid-way.
  always_comb begin
    thr_next = thr;
    if (cnt_next == '0)
      thr_next = (CNT_W+1)'((ON_LEN * (32'(brightness) + 32'd1)) >> 3);
    offset = {1'b0, cnt_next} - (CNT_W+1)'(BLANK_CYCLES);
    lit    = on_next && (offset < thr_next);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) thr <= (CNT_W+1)'(ON_LEN);
    else          thr <= thr_next;
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign lit = on_next;
`endif

  assign accept = frame_valid && frame_ready;

  // A frame arriving on the boundary cycle lands in pend; only a frame already pending is promoted.
  always_comb begin
    disp_next      = disp;
    pend_next      = pend;
    pend_full_next = pend_full;
    if (boundary && pend_full) begin
      disp_next      = pend;
      pend_full_next = 1'b0;
    end
    if (accept) begin
      pend_next      = frame_data;
      pend_full_next = 1'b1;
    end
  end

  always_comb begin
    lcol_next = lit ? ~(4'b0001 << col_next) : 4'b1111;
    led_next  = '1;
    for (int r = 0; r < NUM_ROWS; r++)
      led_next[r] = lit ? ~disp_next[bit_index(col_next, 3'(r))] : 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp        <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      frame_ready <= 1'b1;
      led_q       <= '1;
      lcol_q      <= '1;
    end else begin
      disp        <= disp_next;
      pend        <= pend_next;
      pend_full   <= pend_full_next;
      frame_ready <= !pend_full_next;
      led_q       <= led_next;
      lcol_q      <= lcol_next;
    end
  end

  assign {led8, led7, led6, led5, led4, led3, led2, led1} = led_q;
  assign {lcol4, lcol3, lcol2, lcol1} = lcol_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard testbench for led_matrix_scan with a 16-cycle slot and 2-cycle blanking.
// Accepted frames are queued with their accept edge and popped at the boundary that should display them.
module tb_led_matrix_scan;

  localparam int COL_DIV = 16;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * COL_DIV;

`ifdef LED_SCAN_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          acc_edge;
  } sb_item_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic        frame_ready, frame_start;
  logic        led1, led2, led3, led4, led5, led6, led7, led8;
  logic        lcol1, lcol2, lcol3, lcol4;
  logic [7:0]  leds;
  logic [3:0]  lcols;

  int          checks = 0;
  int          failures = 0;
  int          edges = 0;
  logic [31:0] cur_frame = '0;
  logic        acc_seen = 1'b0;
  logic [31:0] acc_data = '0;
  sb_item_t    sb[$];

  assign leds  = {led8, led7, led6, led5, led4, led3, led2, led1};
  assign lcols = {lcol4, lcol3, lcol2, lcol1};

  led_matrix_scan #(.COL_DIV(COL_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .brightness  (brightness),
    .frame_start (frame_start),
    .led1 (led1), .led2 (led2), .led3 (led3), .led4 (led4),
    .led5 (led5), .led6 (led6), .led7 (led7), .led8 (led8),
    .lcol1 (lcol1), .lcol2 (lcol2), .lcol3 (lcol3), .lcol4 (lcol4)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    acc_seen <= reset_n && frame_valid && frame_ready;
    acc_data <= frame_data;
  end

  // Edge count since reset release gives slot position; a queued frame shows at the first boundary after its accept edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edges     <= 0;
      cur_frame <= '0;
      sb.delete();
    end else begin
      edges <= edges + 1;
      if (acc_seen) sb.push_back('{data: acc_data, acc_edge: edges + 1});
      if (((edges + 1) % FRAME == 0) && (sb.size() > 0) && (sb[0].acc_edge < edges + 1)) begin
        cur_frame <= sb[0].data;
        void'(sb.pop_front());
      end
    end
  end

  function automatic int cnt_of(input int e);
    return e % COL_DIV;
  endfunction

  function automatic int col_of(input int e);
    return (e / COL_DIV) % 4;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_edge_mod(input int m, input int period);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clock);
      if (edges % period == m) return;
    end
  endtask

  task automatic test_reset();
    bit found;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (leds !== 8'hFF) begin failures++; $display("[TB] FAIL reset_leds: got %h expected ff", leds); end
    checks++; if (lcols !== 4'hF) begin failures++; $display("[TB] FAIL reset_lcols: got %h expected f", lcols); end
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", frame_ready); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_start: got %b expected 0", frame_start); end
    step();
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clock);
      if (frame_start === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || edges != FRAME) begin
      failures++;
      $display("[TB] FAIL first_frame_start: seen=%0d at cycle %0d expected cycle %0d", found, edges, FRAME);
    end
    @(negedge clock);
    checks++; if (frame_start !== 1'b0) begin failures++; $display("[TB] FAIL frame_start_width: got %b expected 0", frame_start); end
  endtask

  task automatic test_blanking();
    logic [3:0] exp_lcol;
    logic [7:0] exp_led;
    int c, k;
    wait_edge_mod(0, FRAME);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clock);
      c = cnt_of(edges);
      k = col_of(edges);
      exp_lcol = (c < BLANK) ? 4'hF : ~(4'b0001 << k);
      exp_led  = (c < BLANK) ? 8'hFF : ~cur_frame[k*8 +: 8];
      checks++;
      if (lcols !== exp_lcol) begin failures++; $display("[TB] FAIL blank_lcol col=%0d cnt=%0d: got %h expected %h", k, c, lcols, exp_lcol); end
      checks++;
      if (leds !== exp_led) begin failures++; $display("[TB] FAIL blank_led col=%0d cnt=%0d: got %h expected %h", k, c, leds, exp_led); end
    end
  endtask

  task automatic test_load();
    bit drained;
    step();
    frame_valid = 1'b1;
    frame_data  = 32'h0000_00A5;
    step();
    frame_valid = 1'b0;
    frame_data  = 32'hDEAD_BEEF;
    drained = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (sb.size() == 0) begin drained = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (!drained) begin failures++; $display("[TB] FAIL load_display_latency: %0d frames still queued, expected 0", sb.size()); end
    for (int c = 0; c < 4; c++) begin
      wait_edge_mod(c * COL_DIV + 5, FRAME);
      checks++;
      if (leds !== ~cur_frame[c*8 +: 8]) begin failures++; $display("[TB] FAIL load_led col=%0d: got %h expected %h", c + 1, leds, ~cur_frame[c*8 +: 8]); end
      checks++;
      if (lcols !== ~(4'b0001 << c)) begin failures++; $display("[TB] FAIL load_lcol col=%0d: got %h expected %h", c + 1, lcols, ~(4'b0001 << c)); end
      if (c == 0) begin
        checks++;
        if (leds !== 8'h5A) begin failures++; $display("[TB] FAIL load_col1_pattern: got %h expected 5a", leds); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit hit;
    wait_edge_mod(20, FRAME);
    step();
    frame_valid = 1'b1;
    frame_data  = 32'h1234_5678;
    step();
    frame_data  = 32'hCAFE_F00D;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clock);
      if (edges % FRAME == 0) begin hit = 1'b1; break; end
      checks++;
      if (frame_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_held: got %b expected 0 at cycle %0d", frame_ready, edges); end
    end
    checks++; if (!hit) begin failures++; $display("[TB] FAIL b2b_boundary: boundary not reached, expected within one frame"); end
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_rise: got %b expected 1", frame_ready); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("[TB] FAIL b2b_frame_start: got %b expected 1", frame_start); end
    step();
    frame_valid = 1'b0;
    @(negedge clock);
    checks++; if (frame_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_accept: got ready %b expected 0", frame_ready); end
    wait_edge_mod(5, FRAME);
    checks++; if (leds !== ~cur_frame[7:0]) begin failures++; $display("[TB] FAIL b2b_first_frame: got %h expected %h", leds, ~cur_frame[7:0]); end
    wait_edge_mod(5, FRAME);
    checks++; if (leds !== ~cur_frame[7:0]) begin failures++; $display("[TB] FAIL b2b_second_frame: got %h expected %h", leds, ~cur_frame[7:0]); end
    wait_edge_mod(3 * COL_DIV + 5, FRAME);
    checks++; if (leds !== ~cur_frame[31:24]) begin failures++; $display("[TB] FAIL b2b_second_col4: got %h expected %h", leds, ~cur_frame[31:24]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_led;
    int c, k;
    wait_edge_mod(2, FRAME);
    step();
    frame_valid = 1'b1;
    frame_data  = 32'h0F0F_0F0F;
    step();
    frame_valid = 1'b0;
    wait_edge_mod(2 * COL_DIV + 8, FRAME);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (leds !== 8'hFF) begin failures++; $display("[TB] FAIL midreset_leds: got %h expected ff", leds); end
    checks++; if (lcols !== 4'hF) begin failures++; $display("[TB] FAIL midreset_lcols: got %h expected f", lcols); end
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready: got %b expected 1", frame_ready); end
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pend_cleared: got ready %b expected 1", frame_ready); end
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clock);
      c = cnt_of(edges);
      k = col_of(edges);
      exp_led = (c < BLANK) ? 8'hFF : ~cur_frame[k*8 +: 8];
      checks++;
      if (leds !== exp_led) begin failures++; $display("[TB] FAIL midreset_dark cycle=%0d: got %h expected %h", edges, leds, exp_led); end
    end
  endtask

  task automatic test_brightness();
    logic [2:0] levels [3];
    logic [3:0] exp_lcol;
    int thr, c, k;
    bit lit;
    levels[0] = 3'd3;
    levels[1] = 3'd7;
    levels[2] = 3'd0;
    for (int n = 0; n < 3; n++) begin
      step();
      brightness = levels[n];
      wait_edge_mod(COL_DIV - 1, COL_DIV);
      thr = ((COL_DIV - BLANK) * (int'(levels[n]) + 1)) >> 3;
      for (int i = 0; i < COL_DIV; i++) begin
        @(negedge clock);
        c = cnt_of(edges);
        k = col_of(edges);
        lit = (c >= BLANK) && (!PWM_ON || (c - BLANK) < thr);
        exp_lcol = lit ? ~(4'b0001 << k) : 4'hF;
        checks++;
        if (lcols !== exp_lcol) begin failures++; $display("[TB] FAIL brightness%0d_lcol cnt=%0d: got %h expected %h", levels[n], c, lcols, exp_lcol); end
      end
    end
    brightness = 3'd7;
  endtask

  initial begin
    test_reset();
    test_blanking();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_brightness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Multiplexed driver for the iceFUN 8×4 LED matrix, placed directly downstream of any pattern generator such as the counter demo. It accepts a 32-bit frame image over a valid/ready handshake and double-buffers it. It time-multiplexes the frame onto the active-low row lines `led1..led8` and column lines `lcol1..lcol4`, with dead-time blanking between columns. Frames swap only at frame boundaries, so the matrix never shows a torn image.

## Interface
- `COL_DIV`, default 3000: clocks per column slot (4 kHz column rate / 1 kHz frame at 12 MHz); must be ≥ `BLANK_CYCLES`+8.
- `BLANK_CYCLES`, default 60: clocks at the start of each slot with all columns and rows off.
- `clock` input 1: the single system clock, 12 MHz; all logic on its rising edge.
- `reset_n` input 1: reset, asynchronous assert, active-low; deassertion synchronised externally.
- `frame_data` input 32: frame image; bit `c*8+r` lights row `r+1` of column `c+1` (1 = lit).
- `frame_valid` input 1: `frame_data` is offered.
- `frame_ready` output 1: the pending buffer is empty; transfer occurs when valid && ready on a rising edge.
- `brightness` input 3: global dimming level 0..7 (used only with `LED_SCAN_PWM_EN`).
- `frame_start` output 1: one-cycle pulse on the first cycle of the column-1 slot.
- `led1..led8` output 1 each: row drives, active-low (0 = lit).
- `lcol1..lcol4` output 1 each: column enables, active-low (0 = column selected).

## Operation
- State:
  - slot counter `cnt`, 0..COL_DIV-1.
  - column index `col`, 0..3.
  - `disp` (32 bits, displayed image).
  - `pend` (32 bits) plus `pend_full`.
- Reset values:
  - `cnt`=0, `col`=0, `disp`=0, `pend_full`=0.
  - `frame_ready`=1, `frame_start`=0.
  - All `led*`=1, all `lcol*`=1 (everything dark).
- Counter:
  - `cnt` increments every cycle and wraps to 0 at COL_DIV-1.
  - On wrap, `col` increments mod 4.
  - The wrap from `col`=3 to 0 is the frame boundary.
- Blank window (`cnt` < BLANK_CYCLES): all `lcol*`=1 and all `led*`=1.
- On window (`cnt` ≥ BLANK_CYCLES):
  - `lcol(col+1)`=0 and the other columns are 1.
  - `led(r+1)` = ~`disp[col*8+r]`.
- Handshake:
  - valid && ready loads `pend` and sets `pend_full`; `frame_ready` = !`pend_full`.
  - `frame_data` may change freely when not accepted.
  - `frame_valid` may be held high with no handshake penalty.
- Frame boundary with `pend_full`=1: `disp`←`pend`, `pend_full`←0, so `frame_ready` rises on the next cycle.
- Boundary and acceptance in the same cycle with `pend_full`=0: the new frame goes to `pend`, `disp` is unchanged, and the new frame is displayed at the following boundary (no bypass).
- Boundary with `pend_full`=0: `disp` holds, and the image repeats indefinitely.
- Reset mid-frame: outputs go dark immediately (asynchronous). Pending and displayed frames are discarded; scanning restarts at column 1, `cnt`=0.

## Timing
- All outputs are registered. Next-state values derive from next `cnt`/`col`, so `lcol` asserts on the edge where `cnt` becomes BLANK_CYCLES and deasserts on the edge where `cnt` wraps to 0.
- `frame_start` is high on the cycle where `cnt`=0 and `col`=0. The first pulse is COL_DIV×4 cycles after reset release; there is no pulse on the reset-exit cycle.
- Accept-to-display latency: between 1 and 4×COL_DIV+1 cycles, depending on frame phase.
- Frame period: exactly 4×COL_DIV cycles.

## Configuration
- `LED_SCAN_PWM_EN` defined:
  - Threshold `T = ((COL_DIV-BLANK_CYCLES)*(brightness+1))>>3`, sampled at `cnt`=0 of each slot.
  - The column is lit only while `cnt`-BLANK_CYCLES < T; the remainder of the on window is dark.
  - `brightness`=7 gives the full on window.
- Not defined: `brightness` is ignored (unconnected internally) and the full on window is always lit.

## Structure
- Package `led_scan_pkg`: `NUM_COLS`=4, `NUM_ROWS`=8, `frame_t` (logic [31:0]), and the function mapping (col,row)→bit index.
- One sub-module, `led_scan_timer`: slot counter, column index, blank/on decode, frame-boundary and `frame_start` strobes.
- Frame buffering, handshake and output registers live in the top level.

## Test plan
Use `COL_DIV`=16 and `BLANK_CYCLES`=2.
- Reset: hold `reset_n`=0 → all `led*`, `lcol*`=1, `frame_ready`=1; release → first `frame_start` at cycle 64.
- Load 32'h0000_00A5 → after the next boundary, during the column-1 on window: `lcol1`=0, `{led8..led1}`=8'h5A; columns 2–4 show rows all 1.
- Blanking: check `lcol*`=1 at `cnt`=0,1 of every slot, and exactly one `lcol` low at `cnt`=2..15.
- Back-to-back offers: A accepted, B held valid → `frame_ready` low until the boundary. A is displayed, then B is accepted the next cycle and displayed one frame (64 cycles) later.
- Reset asserted mid-slot in column 3 → outputs dark within the same cycle; `disp` cleared to 0 and `pend_full` to 0 (all rows dark after release).
- With `LED_SCAN_PWM_EN` and `brightness`=3: T=7, so the column is low for `cnt`=2..8 and high for 9..15. With `brightness`=7, the column is low for 2..15.
